// File: rtl/fpu_seq_if.sv
// Core-side request/response handshake bundle for the fpu issue stage.
// The master is the core; the slave is fpu_seq.
interface fpu_seq_if #(
    parameter int FLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [5:0]      req_op;
    logic [2:0]      req_rm;
    logic [FLEN-1:0] req_rs1;
    logic [FLEN-1:0] req_rs2;
    logic [4:0]      req_rd;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [FLEN-1:0] rsp_result;
    logic [4:0]      rsp_rd;
    logic            rsp_illegal;

    modport master (
        output req_valid, req_op, req_rm, req_rs1, req_rs2, req_rd,
        input  req_ready,
        input  rsp_valid, rsp_result, rsp_rd, rsp_illegal,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_op, req_rm, req_rs1, req_rs2, req_rd,
        output req_ready,
        output rsp_valid, rsp_result, rsp_rd, rsp_illegal,
        input  rsp_ready
    );
endinterface

// File: rtl/fpu_seq.sv
// Issue/sequencing stage in front of the fpu datapath; owns the architectural fcsr.
// Latency: LAT(op) cycles from accept to rsp_valid for legal ops, 1 cycle for illegal ones.
// Backpressure: one op in flight; req_ready only in IDLE, response held in DONE until rsp_ready.
module fpu_seq #(
    parameter int FLEN     = 32,
    parameter int LAT_ADD  = 3,
    parameter int LAT_MUL  = 3,
    parameter int LAT_DIV  = 12,
    parameter int LAT_SQRT = 12,
    parameter int LAT_MISC = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    fpu_seq_if.slave        core,
    output logic [5:0]      fpu_operation,
    output logic [FLEN-1:0] fpu_rs1,
    output logic [FLEN-1:0] fpu_rs2,
    output logic [31:0]     fpu_fcsr,
    input  logic [FLEN-1:0] fpu_result,
    input  logic [4:0]      fpu_flags,
    input  logic            csr_we,
    input  logic [31:0]     csr_wdata,
    output logic [31:0]     fcsr,
    output logic            busy
);
    localparam int CW = 8;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [5:0]      op_q;
    logic [FLEN-1:0] rs1_q, rs2_q;
    logic [2:0]      rm_q;
    logic [4:0]      rd_q;
    logic [FLEN-1:0] result_q;
    logic            illegal_q;
    logic [7:0]      fcsr_q;

    logic            accept;
    logic [2:0]      rm_res;
    logic            illegal;
    logic            capture;
    logic [4:0]      flag_in;

    function automatic logic [CW-1:0] lat_of(input logic [5:0] op);
        case (op)
            6'd0:    lat_of = CW'(LAT_ADD);
            6'd1:    lat_of = CW'(LAT_MUL);
            6'd2:    lat_of = CW'(LAT_DIV);
            6'd3:    lat_of = CW'(LAT_SQRT);
            default: lat_of = CW'(LAT_MISC);
        endcase
    endfunction

    assign core.req_ready   = (state_q == IDLE) && !flush;
    assign core.rsp_valid   = (state_q == DONE) && !flush;
    assign core.rsp_result  = result_q;
    assign core.rsp_rd      = rd_q;
    assign core.rsp_illegal = illegal_q;

    assign fpu_operation = op_q;
    assign fpu_rs1       = rs1_q;
    assign fpu_rs2       = rs2_q;
    // Rounding mode is the one resolved at accept, so later frm writes cannot reach the in-flight op.
    assign fpu_fcsr      = {24'b0, rm_q, fcsr_q[4:0]};
    assign fcsr          = {24'b0, fcsr_q};
    assign busy          = (state_q != IDLE);

    always_comb begin
        accept  = core.req_valid && core.req_ready;
        rm_res  = (core.req_rm == 3'b111) ? fcsr_q[7:5] : core.req_rm;
        illegal = (core.req_op > 6'd8) || (rm_res == 3'd5) || (rm_res == 3'd6);
        capture = (state_q == EXEC) && (cnt_q == CW'(1)) && !flush;
        flag_in = capture ? fpu_flags : 5'b0;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = illegal ? DONE : EXEC;
                EXEC:    if (cnt_q == CW'(1)) state_d = DONE;
                DONE:    if (core.rsp_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q     <= '0;
            op_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rm_q      <= '0;
            rd_q      <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            rd_q      <= core.req_rd;
            illegal_q <= illegal;
            if (illegal) begin
                result_q <= '0;
            end else begin
                op_q  <= core.req_op;
                rs1_q <= core.req_rs1;
                rs2_q <= core.req_rs2;
                rm_q  <= rm_res;
                cnt_q <= lat_of(core.req_op);
            end
        end else if ((state_q == EXEC) && !flush) begin
            cnt_q <= cnt_q - CW'(1);
            if (capture) result_q <= fpu_result;
        end
    end

    // Flags are sticky; a coincident CSR write merges with the captured flags instead of losing them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     fcsr_q <= '0;
        else if (csr_we) fcsr_q <= {csr_wdata[7:5], csr_wdata[4:0] | flag_in};
        else             fcsr_q[4:0] <= fcsr_q[4:0] | flag_in;
    end
endmodule

// File: tb/tb_fpu_seq.sv
// Directed bench for fpu_seq: a stimulus process pushes expected responses, a monitor pops and compares.
module tb_fpu_seq;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic [5:0]  fpu_operation;
    logic [31:0] fpu_rs1, fpu_rs2, fpu_fcsr;
    logic [31:0] fpu_result = '0;
    logic [4:0]  fpu_flags = '0;
    logic        csr_we = 1'b0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] fcsr;
    logic        busy;

    always #5 clk = ~clk;

    fpu_seq_if #(.FLEN(32)) core();

    fpu_seq dut (
        .clk           (clk),
        .resetn        (resetn),
        .flush         (flush),
        .core          (core),
        .fpu_operation (fpu_operation),
        .fpu_rs1       (fpu_rs1),
        .fpu_rs2       (fpu_rs2),
        .fpu_fcsr      (fpu_fcsr),
        .fpu_result    (fpu_result),
        .fpu_flags     (fpu_flags),
        .csr_we        (csr_we),
        .csr_wdata     (csr_wdata),
        .fcsr          (fcsr),
        .busy          (busy)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && core.rsp_valid && core.rsp_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rd %0d, expected no response", core.rsp_rd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_result", core.rsp_result, e.res);
                check("rsp_rd", core.rsp_rd, e.rd);
                check("rsp_illegal", core.rsp_illegal, e.ill);
            end
        end
    end

    task automatic issue(input logic [5:0] op, input logic [2:0] rm, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input bit expect_rsp,
                         input logic [31:0] eres, input bit eill);
        bit got = 0;
        core.req_valid = 1'b1;
        core.req_op    = op;
        core.req_rm    = rm;
        core.req_rs1   = a;
        core.req_rs2   = b;
        core.req_rd    = rd;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (core.req_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) check("req_ready_timeout", 0, 1);
        if (expect_rsp) sb.push_back('{res: eres, rd: rd, ill: eill});
        @(posedge clk);
        #1;
        core.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!core.rsp_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [7:0] v);
        csr_we    = 1'b1;
        csr_wdata = {24'b0, v};
        tick();
        csr_we    = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [31:0] held_res;
        core.req_valid = 1'b0;
        core.req_op    = '0;
        core.req_rm    = '0;
        core.req_rs1   = '0;
        core.req_rs2   = '0;
        core.req_rd    = '0;
        core.rsp_ready = 1'b1;

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", core.rsp_valid, 0);
        check("rst_fcsr", fcsr, 0);
        resetn = 1'b1;
        tick();
        check("rst_req_ready", core.req_ready, 1);

        // fadd latency, result and flag capture
        fpu_result = 32'h4040_0000;
        fpu_flags  = 5'b00001;
        issue(6'd0, 3'b000, 32'h3F80_0000, 32'h4000_0000, 5'd1, 1, 32'h4040_0000, 0);
        check("add_fpu_rs1", fpu_rs1, 32'h3F80_0000);
        check("add_fpu_rs2", fpu_rs2, 32'h4000_0000);
        wait_rsp(cyc);
        check("add_latency", cyc, 3);
        tick();
        check("add_fcsr", fcsr, 32'h01);
        check("add_idle", busy, 0);

        // Asynchronous reset in the middle of an fdiv
        fpu_flags = 5'b0;
        issue(6'd2, 3'b000, 32'h4000_0000, 32'h3F80_0000, 5'd2, 0, 0, 0);
        repeat (4) tick();
        check("pre_rst_busy", busy, 1);
        resetn = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_rsp_valid", core.rsp_valid, 0);
        check("arst_fcsr", fcsr, 0);
        tick();
        resetn = 1'b1;
        sb.delete();
        tick();

        // Dynamic rounding mode held through a mid-op frm write
        csr_write(8'h40);
        check("csr_write_fcsr", fcsr, 32'h40);
        fpu_result = 32'h3FB5_04F3;
        issue(6'd2, 3'b111, 32'h4000_0000, 32'h0, 5'd3, 1, 32'h3FB5_04F3, 0);
        for (int i = 0; i < 12; i++) begin
            check("dyn_rm_hold", fpu_fcsr[7:5], 3'b010);
            if (i == 4) begin
                csr_we    = 1'b1;
                csr_wdata = 32'h0;
            end else begin
                csr_we = 1'b0;
            end
            tick();
        end
        check("div_rsp_valid", core.rsp_valid, 1);
        check("div_fcsr", fcsr, 32'h0);
        check("div_fpu_op", fpu_operation, 2);
        tick();

        // Illegal op code and illegal static rounding mode
        csr_write(8'h25);
        issue(6'd9, 3'b000, 32'h1111_1111, 32'h2222_2222, 5'd7, 1, 32'h0, 1);
        check("ill_op_rsp_valid", core.rsp_valid, 1);
        check("ill_op_fcsr", fcsr, 32'h25);
        check("ill_op_fpu_op", fpu_operation, 2);
        tick();
        issue(6'd0, 3'b101, 32'h3333_3333, 32'h4444_4444, 5'd8, 1, 32'h0, 1);
        check("ill_rm_rsp_valid", core.rsp_valid, 1);
        check("ill_rm_fcsr", fcsr, 32'h25);
        check("ill_rm_fpu_op", fpu_operation, 2);
        check("ill_rm_fpu_rs1", fpu_rs1, 32'h4000_0000);
        tick();
        csr_write(8'h00);

        // Response backpressure in DONE
        core.rsp_ready = 1'b0;
        fpu_result = 32'h1234_5678;
        issue(6'd4, 3'b000, 32'h0000_0007, 32'h0, 5'd9, 1, 32'h1234_5678, 0);
        wait_rsp(cyc);
        check("misc_latency", cyc, 1);
        held_res = 32'h1234_5678;
        fpu_result = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            check("stall_rsp_valid", core.rsp_valid, 1);
            check("stall_rsp_result", core.rsp_result, held_res);
            check("stall_rsp_rd", core.rsp_rd, 9);
            check("stall_req_ready", core.req_ready, 0);
            tick();
        end
        core.rsp_ready = 1'b1;
        tick();
        check("release_idle", busy, 0);
        check("release_req_ready", core.req_ready, 1);
        issue(6'd1, 3'b000, 32'h4000_0000, 32'h4000_0000, 5'd10, 1, 32'hDEAD_BEEF, 0);
        check("post_release_busy", busy, 1);
        wait_rsp(cyc);
        check("mul_latency", cyc, 3);
        tick();

        // Flush mid-EXEC drops the op and its flags
        fpu_flags = 5'h10;
        issue(6'd1, 3'b000, 32'h4000_0000, 32'h4040_0000, 5'd11, 0, 0, 0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_rsp_valid", core.rsp_valid, 0);
        check("flush_fcsr", fcsr, 32'h0);
        repeat (4) tick();
        check("flush_no_late_rsp", core.rsp_valid, 0);
        check("flush_fcsr_late", fcsr, 32'h0);

        // CSR write coincident with flag capture
        fpu_result = 32'h40A0_0000;
        issue(6'd1, 3'b000, 32'h4000_0000, 32'h4020_0000, 5'd12, 1, 32'h40A0_0000, 0);
        tick();
        tick();
        csr_we    = 1'b1;
        csr_wdata = 32'h02;
        tick();
        csr_we = 1'b0;
        check("merge_fcsr", fcsr, 32'h12);
        check("merge_rsp_valid", core.rsp_valid, 1);
        repeat (3) tick();
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
